// File: rtl/reset_req_ctrl.sv
// Reset request controller: merges masked reset requests into one stretched, flop-driven
// active-low reset with holdoff, pending re-trigger, and a sticky cause record.
module reset_req_ctrl #(
  parameter int NSRC           = 4,
  parameter int PULSE_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic [NSRC-1:0] req_i,
  input  logic [NSRC-1:0] req_mask_i,
  input  logic            cause_clr_i,
  output logic            rstn_o,
  output logic            ack_o,
  output logic            busy_o,
  output logic [NSRC-1:0] cause_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] acc;

  assign acc    = req_i & ~req_mask_i;
  assign busy_o = (state != ST_IDLE);

  // Async reset lands in ASSERT so release produces the power-on stretch with no ack.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state   <= ST_ASSERT;
      cnt     <= '0;
      pend    <= '0;
      cause_o <= '0;
      ack_o   <= 1'b0;
      rstn_o  <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          rstn_o <= 1'b1;
          if (|acc) begin
            state   <= ST_ASSERT;
            cnt     <= '0;
            cause_o <= acc;
            ack_o   <= 1'b1;
            rstn_o  <= 1'b0;
          end else if (cause_clr_i) begin
            cause_o <= '0;
          end
        end
        ST_ASSERT: begin
          cause_o <= cause_o | acc;
          if (cnt == PULSE_LAST) begin
            state  <= ST_HOLDOFF;
            cnt    <= '0;
            rstn_o <= 1'b1;
          end else begin
            cnt    <= cnt + CNT_W'(1);
            rstn_o <= 1'b0;
          end
        end
        ST_HOLDOFF: begin
          rstn_o <= 1'b1;
          if (cnt == HOLD_LAST) begin
            pend <= '0;
            cnt  <= '0;
            // Requests gathered during holdoff start a fresh reset with a fresh cause.
            if (|(pend | acc)) begin
              state   <= ST_ASSERT;
              cause_o <= pend | acc;
              ack_o   <= 1'b1;
              rstn_o  <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            pend <= pend | acc;
            cnt  <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= ST_ASSERT;
          cnt    <= '0;
          pend   <= '0;
          rstn_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_req_ctrl.sv
// Scoreboard bench for reset_req_ctrl: stimulus queues expected ack/release/idle events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_reset_req_ctrl;

  localparam int EV_ACK  = 0;
  localparam int EV_RISE = 1;
  localparam int EV_IDLE = 2;

  typedef struct {
    int         kind;
    int         cyc;
    logic [3:0] cause;
  } ev_t;

  logic       clk_i = 1'b0;
  logic       arstn_i = 1'b0;
  logic [3:0] req_i = '0;
  logic [3:0] req_mask_i = '0;
  logic       cause_clr_i = 1'b0;
  logic       rstn_o, ack_o, busy_o;
  logic [3:0] cause_o;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  ev_t exp_q[$];
  logic prev_rstn = 1'b0;
  logic prev_busy = 1'b1;

  reset_req_ctrl #(.NSRC(4), .PULSE_CYCLES(16), .HOLDOFF_CYCLES(8), .CNT_W(8)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .req_i(req_i), .req_mask_i(req_mask_i),
    .cause_clr_i(cause_clr_i), .rstn_o(rstn_o), .ack_o(ack_o), .busy_o(busy_o),
    .cause_o(cause_o)
  );

  initial forever #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic push(input int kind, input int c, input logic [3:0] cause);
    ev_t e;
    e.kind = kind; e.cyc = c; e.cause = cause;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d cause=%b, required none", kind, cyc, cause_o);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.cause !== cause_o) begin
        n_fail++;
        $display("FAIL event: got kind=%0d cyc=%0d cause=%b, required kind=%0d cyc=%0d cause=%b",
                 kind, cyc, cause_o, e.kind, e.cyc, e.cause);
      end
    end
  endtask

  // Monitor: ack pulses, rstn_o releases, and busy_o falls are the observable events.
  always @(negedge clk_i) begin
    if (ack_o) check_event(EV_ACK);
    if (rstn_o && !prev_rstn) check_event(EV_RISE);
    if (!busy_o && prev_busy) check_event(EV_IDLE);
    prev_rstn = rstn_o;
    prev_busy = busy_o;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      tick(1);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d events still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // One accepted request at edge k with an uneventful holdoff.
  task automatic expect_pulse(input int k, input logic [3:0] c0, input logic [3:0] cfin);
    push(EV_ACK, k, c0);
    push(EV_RISE, k + 16, cfin);
    push(EV_IDLE, k + 24, cfin);
  endtask

  initial begin
    int k, c2;
    // Power-on
    tick(3);
    #2;
    check("por_rstn", {3'b0, rstn_o}, 4'b0000);
    check("por_ack", {3'b0, ack_o}, 4'b0000);
    check("por_busy", {3'b0, busy_o}, 4'b0001);
    check("por_cause", cause_o, 4'b0000);
    tick(1);
    arstn_i = 1'b1;
    push(EV_RISE, cyc + 16, 4'b0000);
    push(EV_IDLE, cyc + 24, 4'b0000);
    wait_drain("por");

    // Single request pulse, cause sticky afterwards
    tick(2);
    req_i = 4'b0010;
    expect_pulse(cyc + 1, 4'b0010, 4'b0010);
    tick(1);
    req_i = '0;
    wait_drain("single");
    tick(5);
    check("single_sticky", cause_o, 4'b0010);

    // Masked source ignored, then merge a second source mid-pulse
    req_mask_i = 4'b0001;
    req_i = 4'b0001;
    tick(3);
    check("mask_busy", {3'b0, busy_o}, 4'b0000);
    check("mask_cause", cause_o, 4'b0010);
    req_i = 4'b0100;
    k = cyc + 1;
    expect_pulse(k, 4'b0100, 4'b1100);
    tick(1);
    req_i = '0;
    tick(4);
    req_i = 4'b1000;
    tick(1);
    req_i = '0;
    wait_drain("merge");
    req_mask_i = '0;

    // Request in holdoff cycle 3 re-triggers exactly 8 cycles after release
    tick(2);
    req_i = 4'b0001;
    k = cyc + 1;
    push(EV_ACK, k, 4'b0001);
    push(EV_RISE, k + 16, 4'b0001);
    push(EV_ACK, k + 24, 4'b0100);
    push(EV_RISE, k + 40, 4'b0100);
    push(EV_IDLE, k + 48, 4'b0100);
    tick(1);
    req_i = '0;
    tick(18);
    req_i = 4'b0100;
    tick(1);
    req_i = '0;
    wait_drain("pending");

    // Clear in IDLE, request beats clear, clear ignored during ASSERT
    tick(2);
    cause_clr_i = 1'b1;
    tick(1);
    cause_clr_i = 1'b0;
    check("clear_idle", cause_o, 4'b0000);
    tick(1);
    cause_clr_i = 1'b1;
    req_i = 4'b0001;
    expect_pulse(cyc + 1, 4'b0001, 4'b0001);
    tick(1);
    req_i = '0;
    tick(5);
    cause_clr_i = 1'b0;
    check("clear_in_assert", cause_o, 4'b0001);
    wait_drain("clear");

    // Async reset during ASSERT cycle 5
    tick(2);
    req_i = 4'b0010;
    push(EV_ACK, cyc + 1, 4'b0010);
    tick(1);
    req_i = '0;
    tick(4);
    #2 arstn_i = 1'b0;
    #1;
    check("arst_assert_rstn", {3'b0, rstn_o}, 4'b0000);
    check("arst_assert_cause", cause_o, 4'b0000);
    tick(2);
    arstn_i = 1'b1;
    c2 = cyc;
    push(EV_RISE, c2 + 16, 4'b0000);
    push(EV_IDLE, c2 + 24, 4'b0000);
    wait_drain("arst_assert");

    // Async reset during HOLDOFF with a pending request; pending must be dropped
    tick(2);
    req_i = 4'b0010;
    k = cyc + 1;
    push(EV_ACK, k, 4'b0010);
    push(EV_RISE, k + 16, 4'b0010);
    tick(1);
    req_i = '0;
    tick(18);
    req_i = 4'b1000;
    tick(1);
    req_i = '0;
    tick(1);
    check("arst_hold_pre_rstn", {3'b0, rstn_o}, 4'b0001);
    #2 arstn_i = 1'b0;
    #1;
    check("arst_hold_rstn", {3'b0, rstn_o}, 4'b0000);
    check("arst_hold_cause", cause_o, 4'b0000);
    check("arst_hold_ack", {3'b0, ack_o}, 4'b0000);
    tick(2);
    arstn_i = 1'b1;
    c2 = cyc;
    push(EV_RISE, c2 + 16, 4'b0000);
    push(EV_IDLE, c2 + 24, 4'b0000);
    wait_drain("arst_hold");

    tick(30);
    check("final_busy", {3'b0, busy_o}, 4'b0000);
    check("final_cause", cause_o, 4'b0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reset_req_ctrl.md
# reset_req_ctrl

Reset request controller: collects synchronous reset requests from several sources in the clk_i domain (watchdog, software register, debug, …) and generates a glitch-free, stretched, active-low reset rstn_o for the rest of the system. It drives the assertion side of the reset path. Each consuming clock domain passes rstn_o through its own reset synchronizer for clean deassertion. A sticky cause register records which sources triggered the last reset.

## Interface
Parameters:
- NSRC, 4: number of request sources (1..16)
- PULSE_CYCLES, 16: clk_i cycles rstn_o is held low per reset (>= 2)
- HOLDOFF_CYCLES, 8: clk_i cycles after release before new requests are accepted (>= 1)
- CNT_W, 8: counter width; must hold max(PULSE_CYCLES, HOLDOFF_CYCLES)-1

Ports:
- clk_i  input  1  clock
- arstn_i  input  1  reset, asynchronous, active-low
- req_i  input  NSRC  per-source reset request, level or pulse, synchronous to clk_i
- req_mask_i  input  NSRC  1 = source ignored
- cause_clr_i  input  1  clear cause_o; honoured only in IDLE
- rstn_o  output  1  generated reset, active-low, driven directly from a flop
- ack_o  output  1  one-cycle pulse when a reset pulse is launched
- busy_o  output  1  high when state is not IDLE
- cause_o  output  NSRC  sticky record of sources that caused or joined the last reset

## Operation
- Accepted request vector is acc = req_i & ~req_mask_i.
- States:
  - IDLE: rstn_o=1. If acc != 0, go to ASSERT, set cnt=0, cause_o<=acc, ack_o=1 for that cycle. Otherwise, if cause_clr_i=1, set cause_o<=0. On the same edge, a new request wins over cause_clr_i.
  - ASSERT: rstn_o=0. Each edge ORs acc into cause_o. Requests never extend the pulse and produce no extra ack. When cnt==PULSE_CYCLES-1, go to HOLDOFF with cnt=0; otherwise cnt+1.
  - HOLDOFF: rstn_o=1. acc is ORed into pend (NSRC bits). When cnt==HOLDOFF_CYCLES-1:
    - pend|acc != 0: go to ASSERT, cnt=0, cause_o<=pend|acc (replaces the old value), ack_o=1, pend=0.
    - otherwise: go to IDLE.
- cause_clr_i is ignored outside IDLE.
- busy_o = (state != IDLE), combinational from the state register.
- arstn_i low (asynchronous, at any time, including mid-pulse or mid-holdoff):
  - rstn_o=0 immediately; state=ASSERT, cnt=0, pend=0, cause_o=0, ack_o=0.
  - After release, the normal ASSERT count runs (power-on stretch) with no ack_o pulse.
  - cause_o=0 after the power-on pulse means the last reset was power-on.
- Illegal state encodings recover to ASSERT (fail safe: reset asserted).

## Timing
- Request sampled at edge k in IDLE:
  - rstn_o low from edge k through edge k+PULSE_CYCLES-1; rises at edge k+PULSE_CYCLES.
  - ack_o high for exactly the cycle after edge k.
- Holdoff ends at edge k+PULSE_CYCLES+HOLDOFF_CYCLES: state reaches IDLE, or re-enters ASSERT if requests are pending.
- Earliest acceptance of a new request from IDLE is edge k+PULSE_CYCLES+HOLDOFF_CYCLES+1. Back-to-back pulses through the pending path are separated by exactly HOLDOFF_CYCLES high cycles.
- After arstn_i rises, rstn_o rises on the PULSE_CYCLES-th clk_i rising edge.
- Latency from request to rstn_o low is 1 edge. rstn_o never glitches, since it changes only on clk_i or arstn_i.

## Test plan
- Power-on: hold arstn_i low, release, with defaults -> rstn_o low for 16 edges then high; ack_o never pulses; cause_o=0; busy_o falls 8 edges after rstn_o rises.
- Single request: req_i=4'b0010 pulse for 1 cycle in IDLE -> ack_o 1-cycle pulse; rstn_o low exactly 16 cycles; cause_o=4'b0010 and stays sticky in IDLE.
- Masking and merge: req_mask_i=4'b0001 with req_i=4'b0001 -> no reset. Then req_i=4'b0100 in IDLE, and 4'b1000 mid-ASSERT -> one 16-cycle pulse, a single ack_o, cause_o=4'b1100.
- Holdoff pending: request during HOLDOFF cycle 3 -> second pulse starts exactly 8 cycles after the first release; second ack_o pulse; cause_o equals only that request.
- Clear priority: cause_clr_i in IDLE -> cause_o=0 next edge. cause_clr_i with simultaneous req_i=4'b0001 -> cause_o=4'b0001 and a reset starts. cause_clr_i during ASSERT -> ignored.
- Async reset mid-operation: assert arstn_i during ASSERT cycle 5 and separately during HOLDOFF -> rstn_o low immediately without waiting for a clock edge; pend and cause_o cleared; a full 16-cycle pulse follows release.
